tdm_demux4: RTL

//  Receive end of the 4:1 time-division link: takes a stream of slot beats produced by a

---
 rtl/tdm_demux4_pkg.sv | 13 +
 rtl/tdm_demux4_demux1_4.sv | 15 +
 rtl/tdm_demux4.sv | 133 +++++++++++++
 3 files changed

// File: rtl/tdm_demux4_pkg.sv
// Shared TDM link definitions: slot geometry and receiver/scanner state encodings.
// Used by both the transmit-side scanner and the receive-side demux.
package tdm_demux4_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   typedef enum logic {
      ST_HUNT   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_demux4_demux1_4.sv
// Slot index + enable -> one-hot shadow write strobes; purely combinational, no backpressure.
module demux1_4
   import tdm_demux4_pkg::*;
(
   input  logic [SLOT_W-1:0]    sel,
   input  logic                 en,
   output logic [NUM_SLOTS-1:0] stb
);

   always_comb begin
      stb      = '0;
      stb[sel] = en;
   end

endmodule

// File: rtl/tdm_demux4.sv
// TDM 4:1 receive demux with frame_sync lock and flywheel; frames publish 1 cycle after slot-3 beat.
// No backpressure: din_valid gaps simply stall the slot counter.
module tdm_demux4
   import tdm_demux4_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int MISS_LIMIT = 3
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  din,
   input  logic              din_valid,
   input  logic              frame_sync,
   output logic [WIDTH-1:0]  ch_a,
   output logic [WIDTH-1:0]  ch_b,
   output logic [WIDTH-1:0]  ch_c,
   output logic [WIDTH-1:0]  ch_d,
   output logic              frame_valid,
   output logic              locked,
   output logic [SLOT_W-1:0] slot,
   output logic              sync_err
);

   localparam int             MW       = $clog2(MISS_LIMIT + 1);
   localparam logic [MW-1:0]  MISS_MAX = MW'(MISS_LIMIT);

   state_t                state, state_nx;
   logic [SLOT_W-1:0]     slot_nx;
   logic [MW-1:0]         miss_cnt, miss_nx, miss_inc;
   logic                  wr_en;
   logic [SLOT_W-1:0]     wr_slot;
   logic                  err_nx;
   logic [NUM_SLOTS-1:0]  wr_stb;
   // Slot 3 is never stored: it goes straight from din to ch_d on completion.
   logic [WIDTH-1:0]      shadow [NUM_SLOTS-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_HUNT;
         slot     <= '0;
         miss_cnt <= '0;
      end else begin
         state    <= state_nx;
         slot     <= slot_nx;
         miss_cnt <= miss_nx;
      end
   end

   always_comb begin
      state_nx = state;
      slot_nx  = slot;
      miss_nx  = miss_cnt;
      miss_inc = miss_cnt + MW'(1);
      wr_en    = 1'b0;
      wr_slot  = slot;
      err_nx   = 1'b0;
      if (din_valid) begin
         case (state)
            ST_HUNT: begin
               if (frame_sync) begin
                  wr_en    = 1'b1;
                  wr_slot  = '0;
                  slot_nx  = SLOT_W'(1);
                  miss_nx  = '0;
                  state_nx = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (frame_sync && slot != '0) begin
                  // Early sync wins: restart the frame on this beat.
                  err_nx  = 1'b1;
                  wr_en   = 1'b1;
                  wr_slot = '0;
                  slot_nx = SLOT_W'(1);
                  miss_nx = '0;
               end else if (!frame_sync && slot == '0) begin
                  err_nx = 1'b1;
                  if (miss_inc == MISS_MAX) begin
                     state_nx = ST_HUNT;
                     slot_nx  = '0;
                     miss_nx  = '0;
                  end else begin
                     wr_en   = 1'b1;
                     wr_slot = '0;
                     slot_nx = SLOT_W'(1);
                     miss_nx = miss_inc;
                  end
               end else begin
                  wr_en   = 1'b1;
                  slot_nx = slot + SLOT_W'(1);
                  if (frame_sync) miss_nx = '0;
               end
            end
            default: state_nx = ST_HUNT;
         endcase
      end
   end

   always_comb begin
      locked = (state == ST_LOCKED);
   end

   demux1_4 u_demux (
      .sel (wr_slot),
      .en  (wr_en),
      .stb (wr_stb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) shadow[i] <= '0;
         ch_a        <= '0;
         ch_b        <= '0;
         ch_c        <= '0;
         ch_d        <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            if (wr_stb[i]) shadow[i] <= din;
         end
         if (wr_stb[NUM_SLOTS-1]) begin
            ch_a <= shadow[0];
            ch_b <= shadow[1];
            ch_c <= shadow[2];
            ch_d <= din;
         end
         frame_valid <= wr_stb[NUM_SLOTS-1];
         sync_err    <= err_nx;
      end
   end

endmodule
